// File: rtl/reci_share_arb_if.sv
// Bundle of the requester handshake, core operand/result and response signals
// that connect the shared reciprocal arbiter to its neighbours.
interface reci_share_arb_if #(
  parameter int FLT_WIDTH = 23,
  parameter int NUM_REQ   = 4,
  parameter int IDW       = 2
);
  logic                         issue_en;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*FLT_WIDTH-1:0] req_x;
  logic [NUM_REQ-1:0]           req_ready;
  logic [FLT_WIDTH-1:0]         core_x;
  logic [FLT_WIDTH-1:0]         core_result;
  logic [NUM_REQ-1:0]           resp_valid;
  logic [FLT_WIDTH-1:0]         resp_result;
  logic [3:0]                   inflight;

  // Requesters plus the reciprocal core: drive operands, observe grants/results.
  modport master (
    output issue_en, req_valid, req_x, core_result,
    input  req_ready, core_x, resp_valid, resp_result, inflight
  );

  // The arbiter itself.
  modport slave (
    input  issue_en, req_valid, req_x, core_result,
    output req_ready, core_x, resp_valid, resp_result, inflight
  );
endinterface

// File: rtl/reci_share_arb.sv
// Round-robin sharing of one pipelined mantissa-reciprocal core: grants one
// requester per cycle, tracks ownership with a tag pipeline, returns one-hot results.
module reci_share_arb #(
  parameter int FLT_WIDTH = 23,
  parameter int NUM_REQ   = 4,
  parameter int CORE_LAT  = 0,
  parameter int IDW       = 2
) (
  input  logic           clk,
  input  logic           rst,
  reci_share_arb_if.slave bus
);

  logic [IDW-1:0]       rr_ptr_reg;
  logic [IDW-1:0]       rr_ptr_next;
  logic [FLT_WIDTH-1:0] core_x_reg;
  logic                 tag_valid_reg [0:CORE_LAT];
  logic [IDW-1:0]       tag_id_reg    [0:CORE_LAT];
  logic [NUM_REQ-1:0]   resp_valid_reg;
  logic [FLT_WIDTH-1:0] resp_result_reg;
  logic [3:0]           inflight_reg;
  logic [3:0]           inflight_next;

  logic [NUM_REQ-1:0]   grant_onehot;
  logic [IDW-1:0]       grant_id;
  logic                 grant_any;
  logic                 ret_valid;

  // Search upward from rr_ptr, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    int idx;
    grant_onehot = '0;
    grant_id     = '0;
    grant_any    = 1'b0;
    idx          = 0;
    if (!rst && bus.issue_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_any && bus.req_valid[idx]) begin
          grant_any         = 1'b1;
          grant_id          = IDW'(idx);
          grant_onehot[idx] = 1'b1;
        end
      end
    end
  end

  assign ret_valid = tag_valid_reg[CORE_LAT];

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      if (grant_id == IDW'(NUM_REQ - 1)) rr_ptr_next = '0;
      else                               rr_ptr_next = grant_id + IDW'(1);
    end
  end

  always_comb begin
    inflight_next = inflight_reg;
    if (grant_any && !ret_valid)      inflight_next = inflight_reg + 4'd1;
    else if (!grant_any && ret_valid) inflight_next = inflight_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      core_x_reg   <= '0;
      inflight_reg <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      inflight_reg <= inflight_next;
      if (grant_any) core_x_reg <= bus.req_x[int'(grant_id)*FLT_WIDTH +: FLT_WIDTH];
    end
  end

  // Tag stage k is valid exactly when core_result will be meaningful CORE_LAT-k edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= CORE_LAT; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_id_reg[s]    <= '0;
      end
    end else begin
      tag_valid_reg[0] <= grant_any;
      tag_id_reg[0]    <= grant_id;
      for (int s = 1; s <= CORE_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg  <= '0;
      resp_result_reg <= '0;
    end else begin
      resp_valid_reg <= '0;
      if (ret_valid) begin
        resp_valid_reg[tag_id_reg[CORE_LAT]] <= 1'b1;
        resp_result_reg                      <= bus.core_result;
      end
    end
  end

  assign bus.req_ready   = grant_onehot;
  assign bus.core_x      = core_x_reg;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_result = resp_result_reg;
  assign bus.inflight    = inflight_reg;

endmodule

// File: tb/tb_reci_share_arb.sv
// Bench for reci_share_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_reci_share_arb;
  localparam int FW  = 23;
  localparam int NR  = 4;
  localparam int LAT = 2;

  typedef struct {
    int             id;
    logic [FW-1:0]  data;
    int             due;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reci_share_arb_if #(.FLT_WIDTH(FW), .NUM_REQ(NR), .IDW(2)) bus ();

  reci_share_arb #(.FLT_WIDTH(FW), .NUM_REQ(NR), .CORE_LAT(LAT), .IDW(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Core stub: LAT register stages producing the bitwise complement.
  logic [FW-1:0] core_p0 = '0;
  logic [FW-1:0] core_p1 = '0;
  always @(posedge clk) begin
    core_p0 <= ~bus.core_x;
    core_p1 <= core_p0;
  end
  assign bus.core_result = core_p1;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  op_t           m_q[$];
  int            m_rr   = 0;
  int            m_edge = 0;
  logic [NR-1:0] m_rv   = '0;
  logic [FW-1:0] m_res  = '0;

  // Observations from the latest step, for the directed literal checks
  logic [NR-1:0] obs_ready;
  logic [NR-1:0] obs_rv;
  logic [FW-1:0] obs_res;
  logic [3:0]    obs_infl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_grant(input logic r, input logic en, input logic [NR-1:0] v);
    if (r || !en) return -1;
    for (int k = 0; k < NR; k++) begin
      if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check grant, advance model at the edge, check outputs.
  task automatic step(input logic r, input logic en, input logic [NR-1:0] v,
                      input logic [NR*FW-1:0] x);
    int            g;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    rst           = r;
    bus.issue_en  = en;
    bus.req_valid = v;
    bus.req_x     = x;
    #1;
    g         = model_grant(r, en, v);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_rr  = 0;
      m_rv  = '0;
      m_res = '0;
    end else begin
      m_rv = '0;
      if (m_q.size() > 0 && m_q[0].due == m_edge) begin
        m_rv[m_q[0].id] = 1'b1;
        m_res           = m_q[0].data;
        void'(m_q.pop_front());
      end
      if (g >= 0) begin
        m_q.push_back('{id: g, data: ~x[g*FW +: FW], due: m_edge + LAT + 1});
        m_rr = (g + 1) % NR;
      end
    end
    m_edge++;
    #1;
    obs_rv   = bus.resp_valid;
    obs_res  = bus.resp_result;
    obs_infl = bus.inflight;
    chk("resp_valid",  32'(bus.resp_valid),  32'(m_rv));
    chk("resp_result", 32'(bus.resp_result), 32'(m_res));
    chk("inflight",    32'(bus.inflight),    32'(m_q.size()));
  endtask

  function automatic logic [NR*FW-1:0] rand_x();
    logic [NR*FW-1:0] x;
    for (int i = 0; i < NR; i++) x[i*FW +: FW] = FW'($urandom);
    return x;
  endfunction

  task automatic do_reset();
    step(1'b1, 1'b1, '0, '0);
    step(1'b1, 1'b1, '0, '0);
  endtask

  initial begin
    logic [NR*FW-1:0] x;
    int               cnt;
    bus.issue_en  = 1'b0;
    bus.req_valid = '0;
    bus.req_x     = '0;

    // Reset state
    do_reset();
    chk("rst_resp_valid", 32'(obs_rv), 32'h0);
    chk("rst_resp_result", 32'(obs_res), 32'h0);
    chk("rst_inflight", 32'(obs_infl), 32'h0);
    chk("rst_ready", 32'(obs_ready), 32'h0);

    // Single request from requester 2
    x = '0;
    x[2*FW +: FW] = 23'h400000;
    step(1'b0, 1'b1, 4'b0100, x);
    chk("single_ready", 32'(obs_ready), 32'h4);
    chk("single_infl_e0", 32'(obs_infl), 32'd1);
    step(1'b0, 1'b1, 4'b0000, '0);
    chk("single_infl_e1", 32'(obs_infl), 32'd1);
    step(1'b0, 1'b1, 4'b0000, '0);
    chk("single_infl_e2", 32'(obs_infl), 32'd1);
    chk("single_no_early", 32'(obs_rv), 32'h0);
    step(1'b0, 1'b1, 4'b0000, '0);
    chk("single_infl_e3", 32'(obs_infl), 32'd0);
    chk("single_resp_valid", 32'(obs_rv), 32'h4);
    chk("single_resp_result", 32'(obs_res), 32'h3FFFFF);

    // Fairness with all four valid
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 4'b1111, rand_x());
      chk("fair_grant", 32'(obs_ready), 32'(1 << (i % NR)));
      if (i >= 2) chk("fair_inflight", 32'(obs_infl), 32'd3);
      if (i >= 3) chk("fair_resp_id", 32'(obs_rv), 32'(1 << ((i - 3) % NR)));
    end

    // Skip and pointer
    do_reset();
    step(1'b0, 1'b1, 4'b0001, rand_x());
    chk("skip_g0", 32'(obs_ready), 32'h1);
    step(1'b0, 1'b1, 4'b1001, rand_x());
    chk("skip_g3a", 32'(obs_ready), 32'h8);
    step(1'b0, 1'b1, 4'b1001, rand_x());
    chk("skip_g0b", 32'(obs_ready), 32'h1);
    step(1'b0, 1'b1, 4'b1001, rand_x());
    chk("skip_g3c", 32'(obs_ready), 32'h8);
    step(1'b0, 1'b1, 4'b0000, rand_x());
    step(1'b0, 1'b0, 4'b1110, rand_x());
    chk("skip_gated", 32'(obs_ready), 32'h0);
    step(1'b0, 1'b1, 4'b1111, rand_x());
    chk("skip_after_idle", 32'(obs_ready), 32'h1);
    step(1'b0, 1'b1, 4'b0000, rand_x());
    step(1'b0, 1'b1, 4'b0110, rand_x());
    chk("skip_from1", 32'(obs_ready), 32'h2);

    // issue_en gating with three ops in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111, rand_x());
    chk("gate_infl_full", 32'(obs_infl), 32'd3);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'b1111, rand_x());
      chk("gate_ready_off", 32'(obs_ready), 32'h0);
      if (obs_rv != 0) cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b0000, rand_x());
      if (obs_rv != 0) cnt++;
    end
    chk("gate_resp_count", 32'(cnt), 32'd3);
    chk("gate_infl_drained", 32'(obs_infl), 32'd0);

    // Reset mid-flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111, rand_x());
    chk("midrst_infl", 32'(obs_infl), 32'd3);
    step(1'b1, 1'b1, 4'b1111, rand_x());
    chk("midrst_ready", 32'(obs_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'b0000, rand_x());
      chk("midrst_no_resp", 32'(obs_rv), 32'h0);
      chk("midrst_infl0", 32'(obs_infl), 32'd0);
    end
    step(1'b0, 1'b1, 4'b1111, rand_x());
    chk("midrst_grant0", 32'(obs_ready), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 5) != 0, NR'($urandom), rand_x());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reci_share_arb.md
# reci_share_arb

Round-robin arbiter and sequencer that shares one pipelined mantissa-reciprocal core among NUM_REQ requesters. Each requester presents a FLT_WIDTH-bit mantissa with a valid/ready handshake. The block issues at most one operand per cycle into the core and tracks ownership through a tag pipeline matched to the core latency. It returns each result to its owner as a one-cycle one-hot pulse. It sits between the float-divide front ends and the single reciprocal datapath, so the DSP-heavy core is instantiated once.

## Interface
- FLT_WIDTH, 23, mantissa width (hidden bit excluded) of operands and results
- NUM_REQ, 4, number of requesters, 2..8
- CORE_LAT, 0, clock cycles from core_x change to valid core_result, 0..8 (0 = combinational core)
- IDW, 2, requester-id width, equals clog2(NUM_REQ)
- Ports:
  - clk  in  1  single clock, rising edge
  - rst  in  1  synchronous, active-high reset
  - issue_en  in  1  1 = arbitration enabled; 0 = no new grants, in-flight ops still complete
  - req_valid  in  NUM_REQ  per-requester operand valid
  - req_x  in  NUM_REQ*FLT_WIDTH  operands, requester i at bits [i*FLT_WIDTH +: FLT_WIDTH]
  - req_ready  out  NUM_REQ  one-hot-or-zero grant, combinational from req_valid, issue_en, rr_ptr
  - core_x  out  FLT_WIDTH  registered operand to core i_X
  - core_result  in  FLT_WIDTH  core o_result
  - resp_valid  out  NUM_REQ  one-hot-or-zero result pulse
  - resp_result  out  FLT_WIDTH  result, valid when |resp_valid
  - inflight  out  4  number of issued, not yet returned operations

## Operation
- Arbitration: when issue_en=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward mod NUM_REQ. Assert req_ready[i] only.
- Handshake completes when req_valid[i] & req_ready[i] at a rising edge. No grant when issue_en=0 or no valid request.
- rr_ptr: after a grant to i, rr_ptr <= (i+1) mod NUM_REQ. It is unchanged otherwise.
- Issue register: on handshake, core_x <= req_x slice i. Otherwise core_x holds its value; the core output is then ignored because its tag is invalid.
- Tag pipeline: CORE_LAT+1 stages of {valid, id[IDW-1:0]}. Stage0 loads {handshake, granted id} every edge, and stage k loads stage k-1.
- Response: at the edge where the last tag stage is valid, resp_result <= core_result and resp_valid <= onehot(id). Otherwise resp_valid <= 0. resp_result holds its last value.
- The requester must accept resp_valid. There is no response backpressure.
- inflight: +1 on handshake, −1 when the final tag stage is valid, net 0 on simultaneous events. Maximum is CORE_LAT+1, so it never wraps.
- Operand 0 goes through the core like any other value; zero handling belongs to the core.
- Requesters may drop req_valid at any time without a handshake. No state changes.

## Timing
- Reset (rst=1 at an edge):
  - rr_ptr=0, all tag valids=0, core_x=0, resp_valid=0, resp_result=0, inflight=0.
  - req_ready is forced to 0 while rst=1.
- Reset mid-operation discards all in-flight ops. No resp_valid follows for them.
- Latency: handshake at edge E0 gives resp_valid high in the cycle after edge E0+CORE_LAT+1, i.e. CORE_LAT+1 cycles later.
- Throughput: one issue per cycle, sustained. Results return in issue order.
- With K requesters continuously valid, each is granted exactly once per K consecutive cycles.
- Deasserting issue_en takes effect in the same cycle, since req_ready is combinational.

## Test plan
- Bench core stub: CORE_LAT-stage register pipeline computing ~core_x; NUM_REQ=4, CORE_LAT=2.
- Single request:
  - Stimulus: req 2 only, x=23'h400000 at edge E0.
  - Required: req_ready=4'b0100 in the handshake cycle; resp_valid=4'b0100 with resp_result=23'h3FFFFF after edge E3; inflight goes 1,1,1,0.
- Fairness:
  - Stimulus: all four req_valid held high for 12 cycles from reset.
  - Required: grants in order 0,1,2,3,0,1,2,3,...; responses 3 cycles later with matching ids and data; inflight holds at 3.
- Skip and pointer:
  - Stimulus: rr_ptr=1, req_valid=4'b1001.
  - Required: grant to 3, then 0, then 3. Idle cycles leave rr_ptr unchanged.
- issue_en gating:
  - Stimulus: deassert issue_en for 2 cycles with 3 ops in flight.
  - Required: req_ready=0 during the gap; all 3 responses still arrive; no spurious resp_valid.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle with inflight=3.
  - Required: resp_valid stays 0 for the next 4 cycles; inflight=0; the next grant goes to requester 0.
